// File: rtl/eu_pkg.sv
// Shared execution-unit types: the per-lane issue packet carried through the issue FIFO.
package eu_pkg;

  typedef struct packed {
`ifdef EU_DEBUG_MODE
    logic [31:0] inst;
`endif
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic [31:0] inst_addr;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] imm;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [5:0]  shamt;
    logic [1:0]  pid;
  } eu_issue_pkt_t;

endpackage

// File: rtl/eu_lead_ones.sv
// Counts consecutive set bits starting at bit 0; the first clear bit ends the run.
module eu_lead_ones #(
  parameter int unsigned W = 2,
  localparam int unsigned CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  bits,
  output logic [CW-1:0] count
);

  logic run;

  always_comb begin
    count = '0;
    run   = 1'b1;
    for (int unsigned i = 0; i < W; i++) begin
      run   = run & bits[i];
      count = count + CW'(run);
    end
  end

endmodule

// File: rtl/eu_issue_fifo.sv
// Multi-lane in-order issue FIFO with first-word fall-through outputs and redirect flush.
module eu_issue_fifo
  import eu_pkg::*;
#(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned DEPTH = 8,
  parameter type         PKT_T = eu_issue_pkt_t
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush_i,
  input  logic [WAYS-1:0]            in_valid_i,
  input  PKT_T [WAYS-1:0]            in_pkt_i,
  output logic                       in_ready_o,
  output logic [WAYS-1:0]            out_valid_o,
  output PKT_T [WAYS-1:0]            out_pkt_o,
  input  logic [WAYS-1:0]            out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned LW = $clog2(WAYS + 1);
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - WAYS);

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [LW-1:0] enq_avail;
  logic [LW-1:0] enq_num;
  logic [LW-1:0] deq_num;
  logic          empty;
  logic          full;
  logic [AW-1:0] wr_idx [WAYS];
  logic [AW-1:0] rd_idx [WAYS];
  PKT_T          mem [DEPTH];

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign count_o    = count;

  // Ready looks only at the registered occupancy so it never depends on out_ready_i.
  assign in_ready_o = (count <= READY_MAX);

  eu_lead_ones #(.W(WAYS)) u_enq_cnt (
    .bits  (in_valid_i),
    .count (enq_avail)
  );

  eu_lead_ones #(.W(WAYS)) u_deq_cnt (
    .bits  (out_valid_o & out_ready_i),
    .count (deq_num)
  );

  assign enq_num    = (in_ready_o && !flush_i) ? enq_avail : '0;
  assign count_next = count + CW'(enq_num) - CW'(deq_num);

  always_comb begin
    out_valid_o = '0;
    for (int unsigned k = 0; k < WAYS; k++) begin
      out_valid_o[k] = (count > CW'(k));
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < WAYS; k++) begin
      wr_idx[k] = wr_ptr[AW-1:0] + AW'(k);
      rd_idx[k] = rd_ptr[AW-1:0] + AW'(k);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(enq_num);
      rd_ptr <= rd_ptr + (AW+1)'(deq_num);
      count  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < WAYS; k++) begin
      if (LW'(k) < enq_num) begin
        mem[wr_idx[k]] <= in_pkt_i[k];
      end
    end
  end

  // Lanes without a valid entry read as zero so consumers never see stale payload.
  always_comb begin
    out_pkt_o = '0;
    for (int unsigned k = 0; k < WAYS; k++) begin
      if (out_valid_o[k]) begin
        out_pkt_o[k] = mem[rd_idx[k]];
      end
    end
  end

  a_ptr_count: assert property (@(posedge clk) disable iff (!reset_n)
    (wr_ptr - rd_ptr) == (AW+1)'(count));
  a_full_blocks: assert property (@(posedge clk) disable iff (!reset_n)
    full |-> !in_ready_o);
  a_empty_novalid: assert property (@(posedge clk) disable iff (!reset_n)
    empty |-> (out_valid_o == '0));

endmodule

// File: tb/tb_eu_issue_fifo.sv
// Scoreboard bench for eu_issue_fifo (WAYS=2, DEPTH=8): directed scenarios plus random traffic.
module tb_eu_issue_fifo;
  import eu_pkg::*;

  localparam int unsigned WAYS  = 2;
  localparam int unsigned DEPTH = 8;

  typedef eu_issue_pkt_t pkt_t;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           flush_i = 1'b0;
  logic [1:0]     in_valid_i = '0;
  pkt_t [1:0]     in_pkt_i = '0;
  logic           in_ready_o;
  logic [1:0]     out_valid_o;
  pkt_t [1:0]     out_pkt_o;
  logic [1:0]     out_ready_i = '0;
  logic [3:0]     count_o;

  eu_issue_fifo #(.WAYS(WAYS), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_pkt_i    (in_pkt_i),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .out_pkt_o   (out_pkt_o),
    .out_ready_i (out_ready_i),
    .count_o     (count_o)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  pkt_t q[$];
  int   pre_count = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_pkt(input string nm, input pkt_t act, input pkt_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic pkt_t mk(input logic [31:0] addr);
    pkt_t p;
    p           = '0;
    p.rd_addr   = 5'($urandom);
    p.rd_we     = 1'($urandom);
    p.inst_addr = addr;
    p.rs1       = {$urandom, $urandom};
    p.rs2       = {$urandom, $urandom};
    p.imm       = {$urandom, $urandom};
    p.opcode    = 7'($urandom);
    p.funct3    = 3'($urandom);
    p.funct7    = 7'($urandom);
    p.shamt     = 6'($urandom);
    p.pid       = 2'($urandom);
    return p;
  endfunction

  // Monitor: compares visible outputs with the reference queue, then retires accepted lanes.
  always @(negedge clk) begin
    int n;
    if (reset_n) begin
      n = q.size();
      chk("count", 64'(count_o), 64'(n));
      chk("in_ready", 64'(in_ready_o), 64'((DEPTH - n) >= WAYS));
      for (int k = 0; k < 2; k++) begin
        chk("out_valid", 64'(out_valid_o[k]), 64'(n > k));
        chk_pkt("out_pkt", out_pkt_o[k], (n > k) ? q[k] : pkt_t'('0));
      end
      pre_count = n;
      if (flush_i) q.delete();
      else begin
        for (int k = 0; k < 2; k++) begin
          if (k < n && out_ready_i[k]) void'(q.pop_front());
          else break;
        end
      end
    end
  end

  task automatic step(input logic [1:0] v, input pkt_t [1:0] p, input logic [1:0] r,
                      input logic f);
    in_valid_i  = v;
    in_pkt_i    = p;
    out_ready_i = r;
    flush_i     = f;
    @(posedge clk);
    if (reset_n && !f && (DEPTH - pre_count) >= WAYS) begin
      for (int k = 0; k < 2; k++) begin
        if (v[k]) q.push_back(p[k]);
        else break;
      end
    end
    #1;
  endtask

  function automatic pkt_t [1:0] pair(input logic [31:0] base);
    return {mk(base + 32'd4), mk(base)};
  endfunction

  initial begin
    pkt_t [1:0] z;
    logic [31:0] base;
    logic [1:0] rv;
    z = '0;
    base = 32'h1000;

    #2;
    chk("reset_count", 64'(count_o), 64'd0);
    chk("reset_valid", 64'(out_valid_o), 64'd0);
    chk("reset_ready", 64'(in_ready_o), 64'd1);
    #6 reset_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      step(2'b11, pair(32'h100 + 32'(8 * i)), 2'b00, 1'b0);
      chk("fill_count", 64'(count_o), 64'(2 * (i + 1)));
    end
    chk("full_ready", 64'(in_ready_o), 64'd0);
    step(2'b11, pair(32'h200), 2'b00, 1'b0);
    chk("overflow_count", 64'(count_o), 64'd8);

    for (int i = 0; i < 4; i++) begin
      chk("order_l0", 64'(out_pkt_o[0].inst_addr), 64'(32'h100 + 32'(8 * i)));
      chk("order_l1", 64'(out_pkt_o[1].inst_addr), 64'(32'h104 + 32'(8 * i)));
      step(2'b00, z, 2'b11, 1'b0);
    end
    chk("drain_count", 64'(count_o), 64'd0);
    chk("drain_pkt0", 64'(out_pkt_o[0].inst_addr), 64'd0);

    step(2'b11, pair(32'h300), 2'b00, 1'b0);
    step(2'b01, pair(32'h308), 2'b00, 1'b0);
    chk("partial_setup", 64'(count_o), 64'd3);
    step(2'b00, z, 2'b10, 1'b0);
    chk("partial_gap", 64'(count_o), 64'd3);
    step(2'b00, z, 2'b01, 1'b0);
    chk("partial_one", 64'(count_o), 64'd2);

    step(2'b11, pair(32'h400), 2'b00, 1'b0);
    step(2'b11, pair(32'h408), 2'b00, 1'b0);
    chk("conc_setup", 64'(count_o), 64'd6);
    step(2'b11, pair(32'h410), 2'b11, 1'b0);
    chk("conc_count", 64'(count_o), 64'd6);
    chk("conc_ready", 64'(in_ready_o), 64'd1);

    step(2'b00, z, 2'b01, 1'b0);
    chk("flush_setup", 64'(count_o), 64'd5);
    step(2'b11, pair(32'h500), 2'b00, 1'b1);
    chk("flush_count", 64'(count_o), 64'd0);
    chk("flush_valid", 64'(out_valid_o), 64'd0);

    for (int i = 0; i < 200; i++) begin
      rv = 2'($urandom_range(0, 3));
      step(rv, pair(base), 2'($urandom), ($urandom_range(0, 15) == 0));
      base = base + 32'd8;
    end

    step(2'b11, pair(32'h600), 2'b00, 1'b0);
    step(2'b11, pair(32'h608), 2'b00, 1'b0);
    step(2'b00, z, 2'b11, 1'b0);
    #1 reset_n = 1'b0;
    q.delete();
    pre_count = 0;
    #1;
    chk("async_rst_count", 64'(count_o), 64'd0);
    chk("async_rst_valid", 64'(out_valid_o), 64'd0);
    chk("async_rst_ready", 64'(in_ready_o), 64'd1);
    #1 reset_n = 1'b1;
    step(2'b11, pair(32'h700), 2'b00, 1'b0);
    chk("post_rst_count", 64'(count_o), 64'd2);
    chk("post_rst_l0", 64'(out_pkt_o[0].inst_addr), 64'h700);
    step(2'b00, z, 2'b11, 1'b0);
    step(2'b00, z, 2'b00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
